// File: rtl/axi4_stream_pkt_tx.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_stream_pkt_tx
//  Purpose  : AXI4-Stream master that turns one command (byte length + seed)
//             into one packet of incrementing payload bytes, with tkeep and
//             tlast framing, a done pulse and a completed-packet counter.
//  Revision : 1.0 - initial release
// ============================================================================
module axi4_stream_pkt_tx #(
  parameter int unsigned BUS_WIDTH = 32,
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned CNT_W     = 32,
  localparam int unsigned NB       = ((BUS_WIDTH - 1) / 8) + 1,
  localparam int unsigned DW       = NB * 8
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [7:0]       cmd_seed,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [DW-1:0]    m_tdata,
  output logic [NB-1:0]    m_tkeep,
  output logic             m_tlast,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pkt_count
);

  // Wide enough that offset + lane index never overflows, even for the
  // largest legal length.
  localparam int unsigned WW = LEN_W + $clog2(NB + 1) + 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [7:0]         seed_q, seed_d;
  logic [LEN_W-1:0]   off_q, off_d;
  logic               tvalid_q, tvalid_d;
  logic [DW-1:0]      tdata_q, tdata_d;
  logic [NB-1:0]      tkeep_q, tkeep_d;
  logic               tlast_q, tlast_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rdy_q, rdy_d;

  // Beat builder operands and results
  logic [7:0]         b_seed;
  logic [LEN_W-1:0]   b_len;
  logic [LEN_W-1:0]   b_off;
  logic [DW-1:0]      b_data;
  logic [NB-1:0]      b_keep;
  logic               b_last;

  logic               accept;
  logic               xfer;

  assign accept = rdy_q & cmd_valid;
  assign xfer   = tvalid_q & m_tready;

  // Pick the operands of the beat to be loaded next: the first beat of a
  // fresh command in IDLE, otherwise the beat following the current one.
  always_comb begin
    if (state_q == S_IDLE) begin
      b_seed = cmd_seed;
      b_len  = cmd_len;
      b_off  = '0;
    end else begin
      b_seed = seed_q;
      b_len  = len_q;
      b_off  = off_q + LEN_W'(NB);
    end
  end

  // Build one beat: lanes past the end of the packet get keep=0 and data 0.
  always_comb begin
    b_data = '0;
    b_keep = '0;
    for (int i = 0; i < int'(NB); i++) begin
      if ((WW'(b_off) + WW'(i)) < WW'(b_len)) begin
        b_keep[i]          = 1'b1;
        b_data[i*8 +: 8]   = b_seed + 8'(b_off) + 8'(i);
      end
    end
    b_last = (WW'(b_off) + WW'(NB)) >= WW'(b_len);
  end

  // Next-state and next-output logic for the command/packet FSM.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    seed_d   = seed_q;
    off_d    = off_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tlast_d  = tlast_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          len_d  = cmd_len;
          seed_d = cmd_seed;
          off_d  = '0;
          if (cmd_len == '0) begin
            // Empty packet: completes without ever raising tvalid.
            done_d = 1'b1;
            cnt_d  = cnt_q + CNT_W'(1);
          end else begin
            state_d  = S_SEND;
            tvalid_d = 1'b1;
            tdata_d  = b_data;
            tkeep_d  = b_keep;
            tlast_d  = b_last;
          end
        end
      end
      S_SEND: begin
        if (xfer) begin
          if (tlast_q) begin
            state_d  = S_IDLE;
            tvalid_d = 1'b0;
            tdata_d  = '0;
            tkeep_d  = '0;
            tlast_d  = 1'b0;
            done_d   = 1'b1;
            cnt_d    = cnt_q + CNT_W'(1);
          end else begin
            off_d    = b_off;
            tdata_d  = b_data;
            tkeep_d  = b_keep;
            tlast_d  = b_last;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // cmd_ready is registered so it stays low through reset and only rises
  // on the first edge after release.
  always_comb begin
    rdy_d = (state_d == S_IDLE);
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      seed_q   <= '0;
      off_q    <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      seed_q   <= seed_d;
      off_q    <= off_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tlast_q  <= tlast_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      rdy_q    <= rdy_d;
    end
  end

  assign cmd_ready = rdy_q;
  assign m_tvalid  = tvalid_q;
  assign m_tdata   = tdata_q;
  assign m_tkeep   = tkeep_q;
  assign m_tlast   = tlast_q;
  assign busy      = (state_q == S_SEND);
  assign done      = done_q;
  assign pkt_count = cnt_q;

endmodule
`default_nettype wire
